// File: rtl/ws2812_pkg.sv
// Shared state encoding, default timing and frame bit ordering for the WS2812 driver.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int DEF_NUM_LEDS  = 48;
  localparam int DEF_BIT_CYC   = 15;
  localparam int DEF_T0H_CYC   = 5;
  localparam int DEF_T1H_CYC   = 10;
  localparam int DEF_RESET_CYC = 720;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Serial bit k -> framebuf index: pixels ascending, bytes G,R,B, each byte MSB first.
  function automatic int tx_index(input int k);
    return 24 * (k / 24) + 8 * ((k % 24) / 8) + 7 - (k % 8);
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Times one WS2812 data bit: dout high for T0H/T1H cycles, then low until BIT_CYC elapse.
module ws2812_bit_timer #(
  parameter int BIT_CYC = 15,
  parameter int T0H_CYC = 5,
  parameter int T1H_CYC = 10,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic high_end,
  output logic bit_end
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] th;
  logic             active;
  logic             bit_r;

  assign th       = bit_r ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
  assign high_end = active && (cnt == th - 1'b1);
  assign bit_end  = active && (cnt == CNT_W'(BIT_CYC - 1));

  // go wins over bit_end so the next bit starts on the very next cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt    <= '0;
      active <= 1'b0;
      bit_r  <= 1'b0;
      dout   <= 1'b0;
    end else if (go) begin
      cnt    <= '0;
      active <= 1'b1;
      bit_r  <= bit_val;
      dout   <= 1'b1;
    end else if (active) begin
      if (bit_end) begin
        cnt    <= '0;
        active <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (high_end) dout <= 1'b0;
    end
  end

endmodule

// File: rtl/ws2812_driver.sv
// WS2812 frame serialiser: snapshots the framebuffer, shifts it out bit by bit, then latches.
//   state    | meaning
//   ST_IDLE  | line low, waiting for start
//   ST_HIGH  | high phase of the current bit
//   ST_LOW   | low phase of the current bit
//   ST_LATCH | latch/reset gap, done on its final cycle
module ws2812_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = DEF_NUM_LEDS,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int RESET_CYC = DEF_RESET_CYC
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [NUM_LEDS*24-1:0]  framebuf,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    dout
);

  localparam int NBITS = NUM_LEDS * 24;
  localparam int IDX_W = $clog2(NBITS);
  localparam int CNT_W = $clog2(max_int(BIT_CYC, RESET_CYC));

  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && RESET_CYC >= 1)) begin : g_param_check
    $error("ws2812_driver: timing parameters must satisfy 0 < T0H < T1H < BIT and RESET >= 1");
  end

  state_t           state, state_nx;
  logic [NBITS-1:0] fb_ordered;
  logic [NBITS-1:0] shadow;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] cnt;
  logic             go, go_bit, load, advance, latch_done;
  logic             high_end, bit_end;

  // Reorder to transmit order so the shadow only ever shifts by one.
  for (genvar k = 0; k < NBITS; k++) begin : g_order
    assign fb_ordered[k] = framebuf[tx_index(k)];
  end

  assign latch_done = (state == ST_LATCH) && (cnt == CNT_W'(RESET_CYC - 1));
  assign busy       = (state != ST_IDLE);
  assign done       = latch_done;

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    go_bit   = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_HIGH;
          go       = 1'b1;
          go_bit   = fb_ordered[0];
          load     = 1'b1;
        end
      end
      ST_HIGH: begin
        if (high_end) state_nx = ST_LOW;
      end
      ST_LOW: begin
        if (bit_end) begin
          if (bit_idx == IDX_W'(NBITS - 1)) begin
            state_nx = ST_LATCH;
          end else begin
            state_nx = ST_HIGH;
            go       = 1'b1;
            go_bit   = shadow[0];
            advance  = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (latch_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bit 0 goes straight to the timer, so the shadow holds the bits still to come.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      shadow  <= '0;
      bit_idx <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        shadow  <= {1'b0, fb_ordered[NBITS-1:1]};
        bit_idx <= '0;
      end else if (advance) begin
        shadow  <= shadow >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == ST_LATCH && !latch_done) cnt <= cnt + 1'b1;
      else                                  cnt <= '0;
    end
  end

  ws2812_bit_timer #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .CNT_W   (CNT_W)
  ) u_bit_timer (
    .clk      (clk),
    .nrst     (nrst),
    .go       (go),
    .bit_val  (go_bit),
    .dout     (dout),
    .high_end (high_end),
    .bit_end  (bit_end)
  );

endmodule

// File: tb/tb_ws2812_driver.sv
// Randomised frame checks for ws2812_driver: a negedge monitor decodes dout and compares to a byte-level model.
module tb_ws2812_driver;

  localparam int NL    = 48;
  localparam int NBITS = NL * 24;
  localparam int BC    = 15;
  localparam int T0    = 5;
  localparam int T1    = 10;
  localparam int RC    = 720;
  localparam int FRAME = NBITS * BC + RC;

  logic             clk = 1'b0;
  logic             nrst;
  logic [NBITS-1:0] framebuf;
  logic             start;
  logic             busy, done, dout;

  int total = 0;
  int bad   = 0;

  logic [NBITS-1:0] exp_q[$];
  logic [NBITS-1:0] dec;
  int cyc = 0, nbits = 0, hi_len = 0, first_rise = 0, last_rise = 0;
  int tim_err = 0, idle_err = 0, dbl_done = 0, frames = 0;
  logic prev_dout = 1'b0, prev_done = 1'b0;

  always #5 clk = ~clk;

  ws2812_driver #(
    .NUM_LEDS  (NL),
    .BIT_CYC   (BC),
    .T0H_CYC   (T0),
    .T1H_CYC   (T1),
    .RESET_CYC (RC)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .framebuf (framebuf),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .dout     (dout)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected serial stream: pixel by pixel, G then R then B, each byte MSB first.
  function automatic void build_exp(input logic [NBITS-1:0] fb, output logic [NBITS-1:0] seq);
    int k;
    logic [7:0] byte_v;
    k = 0;
    seq = '0;
    for (int p = 0; p < NL; p++) begin
      for (int b = 0; b < 3; b++) begin
        byte_v = fb[24*p + 8*b +: 8];
        for (int i = 7; i >= 0; i--) begin
          seq[k] = byte_v[i];
          k++;
        end
      end
    end
  endfunction

  function automatic logic [NBITS-1:0] rand_fb();
    logic [NBITS-1:0] v;
    v = '0;
    for (int i = 0; i < NBITS / 32; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_frame();
    logic [NBITS-1:0] seq;
    logic [23:0] head;
    int mism;
    chk_val("frame_len", cyc - first_rise + 1, FRAME);
    chk_val("bit_count", nbits, NBITS);
    chk_val("bit_timing", tim_err, 0);
    chk_val("latch_gap", cyc - last_rise + 1, BC + RC);
    chk_val("busy_at_done", busy, 1);
    chk_val("frame_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      build_exp(exp_q.pop_front(), seq);
      mism = 0;
      for (int k = 0; k < NBITS; k++) if (dec[k] !== seq[k]) mism++;
      chk_val("frame_data", mism, 0);
    end
    if (frames == 0) begin
      head = '0;
      for (int i = 0; i < 24; i++) head = {head[22:0], dec[i]};
      chk_val("grb_order", head, 24'hA58001);
    end
    frames++;
    nbits   = 0;
    tim_err = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!nrst) begin
      nbits     = 0;
      hi_len    = 0;
      tim_err   = 0;
      prev_dout = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (dout && !prev_dout) begin
        if (!busy) idle_err++;
        if (nbits == 0) first_rise = cyc;
        else if (cyc - last_rise != BC) tim_err++;
        last_rise = cyc;
        hi_len    = 0;
      end
      if (dout) hi_len++;
      if (!dout && prev_dout) begin
        if (nbits < NBITS) dec[nbits] = (hi_len == T1);
        if (hi_len != T0 && hi_len != T1) tim_err++;
        nbits++;
      end
      if (done && prev_done) dbl_done++;
      if (done) check_frame();
      prev_dout = dout;
      prev_done = done;
    end
  end

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < FRAME + 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_val({tag, "_done_seen"}, n < FRAME + 100, 1);
  endtask

  initial begin
    logic [NBITS-1:0] fb;
    int n, quiet, t_b;

    nrst     = 1'b0;
    start    = 1'b0;
    framebuf = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_dout", dout, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_done", done, 0);
    nrst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk_val("idle_busy", busy, 0);

    // Frame A: known pixel 0, stray start at bit 50, framebuf overwritten at bit 100
    fb = rand_fb();
    fb[23:0] = 24'h0180A5;
    framebuf = fb;
    exp_q.push_back(fb);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_val("start_busy", busy, 1);
    chk_val("start_dout", dout, 1);
    repeat (50 * BC - 1) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50 * BC - 1) @(posedge clk);
    #1;
    framebuf = '1;
    wait_done("a");
    @(posedge clk);
    #1;
    chk_val("busy_fall", busy, 0);
    chk_val("done_width", done, 0);
    chk_val("single_done", frames, 1);

    // Frames B and C back to back with start held high
    fb = '1;
    exp_q.push_back(fb);
    exp_q.push_back(fb);
    start = 1'b1;
    wait_done("b");
    t_b = cyc;
    @(posedge clk);
    #1;
    chk_val("b2b_idle", busy, 0);
    @(posedge clk);
    #1;
    chk_val("b2b_restart", busy, 1);
    start    = 1'b0;
    framebuf = rand_fb();
    wait_done("c");
    chk_val("b2b_period", cyc - t_b, FRAME + 1);

    // Frame D: reset asserted mid-bit while dout is high
    @(posedge clk);
    #1;
    framebuf = rand_fb();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (200 * BC) @(posedge clk);
    #1;
    n = 0;
    while (dout !== 1'b1 && n < 2 * BC) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_val("d_dout_high", dout, 1);
    #2;
    nrst = 1'b0;
    #1;
    chk_val("async_rst_dout", dout, 0);
    chk_val("async_rst_busy", busy, 0);
    chk_val("async_rst_done", done, 0);
    @(posedge clk);
    #1;
    nrst  = 1'b1;
    quiet = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy || dout || done) quiet++;
    end
    chk_val("quiet_after_reset", quiet, 0);

    // Frame E: fresh random frame after reset
    fb = rand_fb();
    framebuf = fb;
    exp_q.push_back(fb);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("e");
    @(posedge clk);
    #1;
    chk_val("done_pulses", frames, 4);
    chk_val("double_done", dbl_done, 0);
    chk_val("idle_activity", idle_err, 0);
    chk_val("exp_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
